// File: rtl/cra_next_adr.sv
// CRAM next-address sequencer: dispatch, skip, call/return stack, stall hold and diagnostic load.
// CRADR is combinational from CUR_ADR, stack top and the current microword fields; all state updates on clk.
module cra_next_adr #(
  parameter int STACK_DEPTH = 16,
  parameter int ADR_W       = 12
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADR_W-1:0]               CRAM_J,
  input  logic                           CRAM_CALL,
  input  logic [4:0]                     CRAM_DISP,
  input  logic [5:0]                     CRAM_SKIP,
  input  logic                           SKIP_TRUE,
  input  logic [3:0]                     DISP_DATA,
  input  logic [ADR_W-1:0]               DR_ADR,
  input  logic                           STALL,
  input  logic                           DIAG_LOAD,
  input  logic [ADR_W-1:0]               DIAG_ADR,
  output logic [ADR_W-1:0]               CRADR,
  output logic [ADR_W-1:0]               CUR_ADR,
  output logic [$clog2(STACK_DEPTH):0]   STACK_LVL,
  output logic                           STACK_OVF,
  output logic                           STACK_UNF
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [4:0] DISP_RET  = 5'h11;
  localparam logic [4:0] DISP_DRAM = 5'h12;
  localparam logic [4:0] DISP_16W  = 5'h13;
  localparam logic [4:0] DISP_2W   = 5'h14;

  logic [ADR_W-1:0] stack_mem [STACK_DEPTH];

  logic [LVL_W-1:0] lvl;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] push_idx;
  logic             stack_empty;
  logic             stack_full;
  logic [ADR_W-1:0] tos;
  logic             is_ret;
  logic             seq_en;
  logic             do_skip;
  logic [ADR_W-1:0] base_adr;
  logic [ADR_W-1:0] next_adr;

  assign stack_empty = (lvl == '0);
  assign stack_full  = (lvl == LVL_W'(STACK_DEPTH));
  assign top_idx     = PTR_W'(lvl - LVL_W'(1));
  assign push_idx    = PTR_W'(lvl);
  // An empty stack reads as zero so RETURN degenerates to a plain jump to J.
  assign tos         = stack_empty ? '0 : stack_mem[top_idx];

  assign is_ret  = (CRAM_DISP == DISP_RET);
  assign seq_en  = !STALL && !DIAG_LOAD;
  assign do_skip = (CRAM_SKIP != 6'd0) && SKIP_TRUE;

  always_comb begin
    base_adr = CRAM_J;
    case (CRAM_DISP)
      DISP_RET:  base_adr = tos | CRAM_J;
      DISP_DRAM: base_adr = DR_ADR;
      DISP_16W:  base_adr = CRAM_J | ADR_W'(DISP_DATA);
      DISP_2W:   base_adr = CRAM_J | ADR_W'(DISP_DATA[0]);
      default:   base_adr = CRAM_J;
    endcase
  end

  always_comb begin
    next_adr = '0;
    if (reset) begin
      next_adr = '0;
    end else if (DIAG_LOAD) begin
      next_adr = DIAG_ADR;
    end else if (STALL) begin
      next_adr = CUR_ADR;
    end else begin
      next_adr = do_skip ? (base_adr | ADR_W'(1)) : base_adr;
    end
  end

  assign CRADR     = next_adr;
  assign STACK_LVL = lvl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      CUR_ADR <= '0;
    end else begin
      CUR_ADR <= next_adr;
    end
  end

  // Storage needs no reset: entries above lvl are never read.
  always_ff @(posedge clk) begin
    if (!reset && seq_en && CRAM_CALL) begin
      if (is_ret && !stack_empty) begin
        stack_mem[top_idx] <= CUR_ADR;
      end else if (!stack_full) begin
        stack_mem[push_idx] <= CUR_ADR;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl       <= '0;
      STACK_OVF <= 1'b0;
      STACK_UNF <= 1'b0;
    end else if (seq_en) begin
      if (CRAM_CALL && is_ret) begin
        if (stack_empty) begin
          lvl       <= LVL_W'(1);
          STACK_UNF <= 1'b1;
        end
      end else if (CRAM_CALL) begin
        if (stack_full) begin
          STACK_OVF <= 1'b1;
        end else begin
          lvl <= lvl + LVL_W'(1);
        end
      end else if (is_ret) begin
        if (stack_empty) begin
          STACK_UNF <= 1'b1;
        end else begin
          lvl <= lvl - LVL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cra_next_adr.sv
// Bench for cra_next_adr: directed scenarios then random microword streams against a queue-based model.
module tb_cra_next_adr;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] cram_j;
  logic        cram_call;
  logic [4:0]  cram_disp;
  logic [5:0]  cram_skip;
  logic        skip_true;
  logic [3:0]  disp_data;
  logic [11:0] dr_adr;
  logic        stall;
  logic        diag_load;
  logic [11:0] diag_adr;
  logic [11:0] cradr;
  logic [11:0] cur_adr;
  logic [4:0]  stack_lvl;
  logic        stack_ovf;
  logic        stack_unf;

  cra_next_adr #(.STACK_DEPTH(16), .ADR_W(12)) dut (
    .clk(clk), .reset(reset),
    .CRAM_J(cram_j), .CRAM_CALL(cram_call), .CRAM_DISP(cram_disp),
    .CRAM_SKIP(cram_skip), .SKIP_TRUE(skip_true), .DISP_DATA(disp_data),
    .DR_ADR(dr_adr), .STALL(stall), .DIAG_LOAD(diag_load), .DIAG_ADR(diag_adr),
    .CRADR(cradr), .CUR_ADR(cur_adr), .STACK_LVL(stack_lvl),
    .STACK_OVF(stack_ovf), .STACK_UNF(stack_unf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: current address, return stack as a queue, sticky flags.
  logic [11:0] m_cur;
  logic [11:0] m_stk[$];
  bit          m_ovf;
  bit          m_unf;

  function automatic logic [11:0] m_next();
    logic [11:0] top;
    logic [11:0] base;
    if (reset) return 12'h000;
    if (diag_load) return diag_adr;
    if (stall) return m_cur;
    top = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 12'h000;
    if (cram_disp == 5'h11)      base = top | cram_j;
    else if (cram_disp == 5'h12) base = dr_adr;
    else if (cram_disp == 5'h13) base = cram_j | {8'h00, disp_data};
    else if (cram_disp == 5'h14) base = cram_j | {11'h000, disp_data[0]};
    else                         base = cram_j;
    if (cram_skip != 0 && skip_true) base = base | 12'h001;
    return base;
  endfunction

  task automatic model_reset();
    m_cur = 12'h000;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".cradr"}, {20'h0, cradr}, {20'h0, m_next()});
    check({tag, ".cur"}, {20'h0, cur_adr}, {20'h0, m_cur});
    check({tag, ".lvl"}, {27'h0, stack_lvl}, 32'(m_stk.size()));
    check({tag, ".ovf"}, {31'h0, stack_ovf}, {31'h0, m_ovf});
    check({tag, ".unf"}, {31'h0, stack_unf}, {31'h0, m_unf});
  endtask

  task automatic drive(input string tag, input logic [11:0] j, input logic call, input logic [4:0] disp,
                       input logic [5:0] skip, input logic st, input logic [3:0] dd, input logic [11:0] dr,
                       input logic stl, input logic dg, input logic [11:0] dga);
    cram_j = j; cram_call = call; cram_disp = disp; cram_skip = skip; skip_true = st;
    disp_data = dd; dr_adr = dr; stall = stl; diag_load = dg; diag_adr = dga;
    #1;
    compare_all(tag);
  endtask

  task automatic tick();
    logic [11:0] nxt;
    bit ret;
    nxt = m_next();
    ret = (cram_disp == 5'h11);
    @(posedge clk);
    if (!stall && !diag_load) begin
      if (cram_call && ret) begin
        if (m_stk.size() == 0) begin m_unf = 1; m_stk.push_back(m_cur); end
        else m_stk[m_stk.size()-1] = m_cur;
      end else if (cram_call) begin
        if (m_stk.size() == 16) m_ovf = 1;
        else m_stk.push_back(m_cur);
      end else if (ret) begin
        if (m_stk.size() == 0) m_unf = 1;
        else void'(m_stk.pop_back());
      end
    end
    m_cur = nxt;
    @(negedge clk);
  endtask

  task automatic jmp(input logic [11:0] j);
    drive("jmp", j, 0, 5'h00, 6'h00, 0, 4'h0, 12'h000, 0, 0, 12'h000);
    tick();
  endtask

  initial begin
    logic [11:0] held;
    logic [4:0]  held_lvl;
    logic [4:0]  dsel;
    // Reset with J=0x100 already on the field inputs.
    cram_j = 12'h100; cram_call = 0; cram_disp = 0; cram_skip = 0; skip_true = 0;
    disp_data = 0; dr_adr = 0; stall = 0; diag_load = 0; diag_adr = 0;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst.cradr", {20'h0, cradr}, 32'h0);
    check("rst.cur", {20'h0, cur_adr}, 32'h0);
    check("rst.lvl", {27'h0, stack_lvl}, 32'h0);
    check("rst.flags", {30'h0, stack_ovf, stack_unf}, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    drive("first", 12'h100, 0, 5'h00, 6'h00, 0, 4'h0, 12'h000, 0, 0, 12'h000);
    tick();
    check("first.cur", {20'h0, cur_adr}, 32'h100);

    // Skip on and off.
    jmp(12'h040);
    drive("skip1", 12'h200, 0, 5'h00, 6'h05, 1, 4'h0, 12'h000, 0, 0, 12'h000);
    check("skip1.val", {20'h0, cradr}, 32'h201);
    drive("skip0", 12'h200, 0, 5'h00, 6'h05, 0, 4'h0, 12'h000, 0, 0, 12'h000);
    check("skip0.val", {20'h0, cradr}, 32'h200);
    tick();

    // Dispatches.
    drive("d16", 12'h3F0, 0, 5'h13, 6'h00, 0, 4'hA, 12'h000, 0, 0, 12'h000);
    check("d16.val", {20'h0, cradr}, 32'h3FA);
    drive("dram", 12'h3F0, 0, 5'h12, 6'h00, 0, 4'hA, 12'h5C4, 0, 0, 12'h000);
    check("dram.val", {20'h0, cradr}, 32'h5C4);
    tick();

    // Call then return.
    jmp(12'h123);
    drive("call", 12'h700, 1, 5'h00, 6'h00, 0, 4'h0, 12'h000, 0, 0, 12'h000);
    tick();
    check("call.lvl", {27'h0, stack_lvl}, 32'h1);
    drive("ret", 12'h001, 0, 5'h11, 6'h00, 0, 4'h0, 12'h000, 0, 0, 12'h000);
    check("ret.val", {20'h0, cradr}, 32'h123);
    tick();
    check("ret.lvl", {27'h0, stack_lvl}, 32'h0);

    // Overflow then underflow.
    for (int i = 0; i < 17; i++) begin
      drive("callN", 12'(i * 16), 1, 5'h00, 6'h00, 0, 4'h0, 12'h000, 0, 0, 12'h000);
      tick();
    end
    check("ovf.lvl", {27'h0, stack_lvl}, 32'd16);
    check("ovf.flag", {31'h0, stack_ovf}, 32'h1);
    for (int i = 0; i < 17; i++) begin
      drive("retN", 12'h0F0, 0, 5'h11, 6'h00, 0, 4'h0, 12'h000, 0, 0, 12'h000);
      if (i == 16) check("unf.cradr", {20'h0, cradr}, 32'h0F0);
      tick();
    end
    check("unf.lvl", {27'h0, stack_lvl}, 32'h0);
    check("unf.flag", {31'h0, stack_unf}, 32'h1);

    // Stall hold, then diagnostic load during stall.
    jmp(12'h321);
    drive("pre", 12'h555, 1, 5'h00, 6'h00, 0, 4'h0, 12'h000, 0, 0, 12'h000);
    tick();
    held = cur_adr;
    held_lvl = stack_lvl;
    for (int i = 0; i < 3; i++) begin
      drive("stall", 12'h7A5, 1, 5'h11, 6'h3F, 1, 4'hF, 12'hABC, 1, 0, 12'h000);
      check("stall.hold", {20'h0, cradr}, {20'h0, held});
      tick();
      check("stall.lvl", {27'h0, stack_lvl}, {27'h0, held_lvl});
    end
    drive("diag", 12'h7A5, 1, 5'h11, 6'h3F, 1, 4'hF, 12'hABC, 1, 1, 12'h777);
    check("diag.val", {20'h0, cradr}, 32'h777);
    tick();

    // Asynchronous reset mid-stall.
    drive("stall2", 12'h0AA, 1, 5'h00, 6'h00, 0, 4'h0, 12'h000, 1, 0, 12'h000);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all("arst");
    @(negedge clk);
    reset = 1'b0;

    // Random microword stream.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0: dsel = 5'h11;
        1: dsel = 5'h12;
        2: dsel = 5'h13;
        3: dsel = 5'h14;
        4: dsel = 5'h11;
        default: dsel = 5'($urandom);
      endcase
      drive("rand", {1'b0, 11'($urandom)}, ($urandom_range(0, 9) < 4), dsel,
            ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'h00, 1'($urandom), 4'($urandom),
            12'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0), 12'($urandom));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cra_next_adr.md
Name: cra_next_adr

Overview:
- CRAM address sequencer; sits directly upstream of the CRAM storage block.
- Each cycle it takes the fields of the microword currently read out (J, CALL, DISP, SKIP) plus datapath conditions, and forms the next CRADR.
- CRAM storage latches that CRADR on clk and presents the next microword on the following cycle.
- Provides 2-way skip, 16-way and DRAM dispatch, a 16-deep subroutine call/return stack, a stall hold, and a diagnostic address load.

Parameters:
STACK_DEPTH, 16, number of call-stack entries (power of two, 2..64)
ADR_W, 12, CRAM address width

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
CRAM_J  input  12  J field of current microword (bits [11:0], bit 11 unused = 0)
CRAM_CALL  input  1  current word is a subroutine call
CRAM_DISP  input  5  DISP/SPEC shared field of current word
CRAM_SKIP  input  6  skip selector; nonzero = skip requested
SKIP_TRUE  input  1  resolved skip condition from condition logic
DISP_DATA  input  4  datapath dispatch bits
DR_ADR  input  12  instruction dispatch address from DRAM
STALL  input  1  hold sequencer (MBOX wait)
DIAG_LOAD  input  1  force CRADR from DIAG_ADR
DIAG_ADR  input  12  diagnostic CRAM address
CRADR  output  12  next CRAM address (combinational from state and fields)
CUR_ADR  output  12  registered address of microword now on the field inputs
STACK_LVL  output  5  current stack occupancy 0..16
STACK_OVF  output  1  sticky: push attempted when full
STACK_UNF  output  1  sticky: return attempted when empty

Behaviour:
- Reset (async, any time, including mid-call): CUR_ADR=0, STACK_LVL=0, STACK_OVF=0, STACK_UNF=0, stack contents don't-care; CRADR forced 0 while reset high. First word executed after release is at address 0.
- CRADR priority:
  1. DIAG_LOAD → DIAG_ADR (overrides STALL).
  2. STALL → CUR_ADR (re-read same word).
  3. Otherwise formed from the fields below.
- DISP decode:
  - 5'h11 RETURN: base = top-of-stack | CRAM_J.
  - 5'h12 DRAM: base = DR_ADR.
  - 5'h13 16-way: base = CRAM_J | {8'b0, DISP_DATA}.
  - 5'h14 2-way: base = CRAM_J | {11'b0, DISP_DATA[0]}.
  - Any other value (including 0x00-0x0F SPEC codes): base = CRAM_J.
- Skip: if CRAM_SKIP != 0 and SKIP_TRUE, CRADR = base | 12'h001; otherwise CRADR = base. Skip applies after dispatch (OR, no carry).
- CUR_ADR <= CRADR every clk (stall case makes this a hold).
- Stack updates only when !STALL and !DIAG_LOAD:
  - CALL alone: push CUR_ADR; STACK_LVL+1.
  - RETURN alone: pop; STACK_LVL-1.
  - CALL and RETURN together: top used for CRADR, then replaced by CUR_ADR; STACK_LVL unchanged.
- Full (STACK_LVL=16) and CALL without RETURN: entry discarded, STACK_LVL stays 16, STACK_OVF<=1.
- Empty (STACK_LVL=0) and RETURN: top reads as 0, so CRADR = CRAM_J | skip. STACK_UNF<=1, STACK_LVL stays 0. If CALL is also set, push CUR_ADR and STACK_LVL becomes 1.
- STACK_OVF and STACK_UNF are cleared only by reset.
- Address arithmetic is OR-only; there is no incrementer and no wrap logic. Address 12'hFFF is legal.

Test Plan:
- Reset release with J=12'h100, no skip or dispatch → CRADR=0 during reset; CUR_ADR=0 then 12'h100 after first clk.
- CUR_ADR=12'h040, J=12'h200, SKIP=6'h05, SKIP_TRUE=1 → CRADR=12'h201; same with SKIP_TRUE=0 → 12'h200.
- DISP=5'h13, J=12'h3F0, DISP_DATA=4'hA → CRADR=12'h3FA. DISP=5'h12, DR_ADR=12'h5C4 → CRADR=12'h5C4.
- CALL at CUR_ADR=12'h123 (J=12'h700), then RETURN with J=12'h001 → STACK_LVL 1→0, CRADR=12'h123.
- 17 consecutive CALLs → STACK_LVL=16, STACK_OVF=1. Then 17 RETURNs → STACK_LVL=0, STACK_UNF=1 on the 17th, with CRADR=J on that cycle.
- STALL held 3 cycles → CRADR=CUR_ADR constant and stack unchanged. DIAG_LOAD with DIAG_ADR=12'h777 during STALL → CRADR=12'h777. Async reset asserted mid-stall → all outputs 0 immediately.
